// File: rtl/ul_pwr_pkg.sv
// Shared constants, FSM state, beat tag and output saturation for the
// uplink per-antenna RBG power accumulator.
package ul_pwr_pkg;

    localparam int RE_PER_PRB = 12;
    localparam int ACC_W      = 40;
    localparam int PWR_W      = 32;
    localparam int NUM_LANES  = 4;
    localparam int NUM_ANT    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Control tag that travels alongside the squaring pipeline
    typedef struct packed {
        logic       dump;
        logic       grp;
        logic [3:0] rbg;
    } beat_tag_t;

    // Shift the accumulator down, clamp to all-ones if anything survives above bit 31
    function automatic logic [PWR_W-1:0] sat_shift(input logic [ACC_W-1:0] v,
                                                   input int unsigned       sh);
        logic [ACC_W-1:0] s;
        s = v >> sh;
        return (|s[ACC_W-1:PWR_W]) ? '1 : s[PWR_W-1:0];
    endfunction

endpackage

// File: rtl/ul_pwr_sq.sv
// One lane of I^2 + Q^2: squares registered in stage 1, sum registered in stage 2.
module ul_pwr_sq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sample,
    output logic [31:0] pwr
);
    logic signed [15:0] i_s, q_s;
    logic signed [30:0] i_x, q_x;
    logic        [30:0] i_sq, q_sq;

    assign i_s = sample[31:16];
    assign q_s = sample[15:0];
    // Squares of 16-bit signed values top out at 2^30, so 31 bits hold them exactly
    assign i_x = 31'(i_s);
    assign q_x = 31'(q_s);

    // Stage 1 squares, stage 2 sum (max 2^31, fits 32 bits unsigned)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_sq <= '0;
            q_sq <= '0;
            pwr  <= '0;
        end else begin
            i_sq <= i_x * i_x;
            q_sq <= q_x * q_x;
            pwr  <= {1'b0, i_sq} + {1'b0, q_sq};
        end
    end

endmodule

// File: rtl/ul_ant_power_acc.sv
// Per-antenna RBG power accumulator: four lanes of I^2+Q^2 folded into eight
// 40-bit accumulators, dumped as saturated 32-bit words at each RBG end.
module ul_ant_power_acc
    import ul_pwr_pkg::*;
#(
    parameter int RBG_SIZE  = 16,
    parameter int OUT_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vld,
    input  logic        i_sop,
    input  logic        i_eop,
    input  logic        i_grp,
    input  logic [31:0] i_ant0,
    input  logic [31:0] i_ant1,
    input  logic [31:0] i_ant2,
    input  logic [31:0] i_ant3,
    input  logic [3:0]  i_rbg_idx,
    input  logic        i_last_prb,
    output logic [31:0] o_ant_power0,
    output logic [31:0] o_ant_power1,
    output logic [31:0] o_ant_power2,
    output logic [31:0] o_ant_power3,
    output logic [31:0] o_ant_power4,
    output logic [31:0] o_ant_power5,
    output logic [31:0] o_ant_power6,
    output logic [31:0] o_ant_power7,
    output logic [3:0]  o_rbg_idx,
    output logic        o_pwr_vld,
    output logic        o_err
);
    localparam int STAGES = 2;

    state_t     state;
    logic [3:0] re_cnt, prb_cnt, rbg_lat;
    logic [3:0] re_eff, prb_eff, rbg_cur;
    logic       take, rbg_end, err_n;
    beat_tag_t  tag_in;

    logic      [STAGES:1]                vld_pipe;
    beat_tag_t [STAGES:1]                tag_pipe;
    logic      [NUM_LANES-1:0][31:0]     lane_in, lane_pwr;
    logic      [NUM_ANT-1:0][ACC_W-1:0]  acc, acc_sum;
    logic      [NUM_ANT-1:0][PWR_W-1:0]  pwr_q;

    assign lane_in = {i_ant3, i_ant2, i_ant1, i_ant0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ul_pwr_sq u_sq (
            .clk    (clk),
            .rst_n  (rst_n),
            .sample (lane_in[g]),
            .pwr    (lane_pwr[g])
        );
    end

    // Beat decode: a sop is applied first, then the eop is judged against the updated count
    always_comb begin
        take    = 1'b0;
        rbg_end = 1'b0;
        err_n   = 1'b0;
        re_eff  = re_cnt;
        prb_eff = (state == IDLE) ? 4'd0 : prb_cnt;
        rbg_cur = rbg_lat;
        if (i_vld) begin
            if (state == IDLE && !i_sop) begin
                err_n = 1'b1;
            end else begin
                take = 1'b1;
                if (i_sop) begin
                    re_eff = '0;
                    if (state == ACC && re_cnt != '0) err_n = 1'b1;
                    if (state == IDLE) rbg_cur = i_rbg_idx;
                end
                if (i_eop) begin
                    if (re_eff != 4'(RE_PER_PRB - 1)) err_n = 1'b1;
                    rbg_end = (prb_eff == 4'(RBG_SIZE - 1)) || i_last_prb;
                end
            end
        end
        tag_in.dump = rbg_end;
        tag_in.grp  = i_grp;
        tag_in.rbg  = rbg_cur;
    end

    // Framing FSM: RE/PRB counters, RBG index latch, error strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            re_cnt  <= '0;
            prb_cnt <= '0;
            rbg_lat <= '0;
            o_err   <= 1'b0;
        end else begin
            o_err <= err_n;
            if (take) begin
                rbg_lat <= rbg_cur;
                if (i_eop) begin
                    re_cnt <= '0;
                    if (rbg_end) begin
                        state   <= IDLE;
                        prb_cnt <= '0;
                    end else begin
                        state   <= ACC;
                        prb_cnt <= prb_eff + 4'd1;
                    end
                end else begin
                    state   <= ACC;
                    re_cnt  <= re_eff + 4'd1;
                    prb_cnt <= prb_eff;
                end
            end
        end
    end

    // Valid/tag shift register kept in step with the squaring pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], take};
            tag_pipe <= {tag_pipe[STAGES-1:1], tag_in};
        end
    end

    // Only the antennas of the beat's group pick up that beat's lane sums
    always_comb begin
        for (int a = 0; a < NUM_ANT; a++) begin
            acc_sum[a] = acc[a];
            if (vld_pipe[STAGES] && (tag_pipe[STAGES].grp == (a >= NUM_LANES)))
                acc_sum[a] = acc[a] + ACC_W'(lane_pwr[a % NUM_LANES]);
        end
    end

    // Accumulate, or on a dump beat publish the final sums and restart from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            pwr_q     <= '0;
            o_rbg_idx <= '0;
            o_pwr_vld <= 1'b0;
        end else begin
            o_pwr_vld <= vld_pipe[STAGES] && tag_pipe[STAGES].dump;
            if (vld_pipe[STAGES]) begin
                if (tag_pipe[STAGES].dump) begin
                    for (int a = 0; a < NUM_ANT; a++)
                        pwr_q[a] <= sat_shift(acc_sum[a], OUT_SHIFT);
                    acc       <= '0;
                    o_rbg_idx <= tag_pipe[STAGES].rbg;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign o_ant_power0 = pwr_q[0];
    assign o_ant_power1 = pwr_q[1];
    assign o_ant_power2 = pwr_q[2];
    assign o_ant_power3 = pwr_q[3];
    assign o_ant_power4 = pwr_q[4];
    assign o_ant_power5 = pwr_q[5];
    assign o_ant_power6 = pwr_q[6];
    assign o_ant_power7 = pwr_q[7];

endmodule

// File: tb/tb_ul_ant_power_acc.sv
// Directed bench for ul_ant_power_acc: three instances share one stimulus
// stream (RBG 2 / shift 8, RBG 16 / shift 0, RBG 16 / shift 8).
module tb_ul_ant_power_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0, sop = 1'b0, eop = 1'b0, grp = 1'b0, last = 1'b0;
    logic [31:0] ant = '0;
    logic [3:0]  idx = '0;

    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic [31:0] pc [8];
    logic [3:0]  ia, ib, ic;
    logic        va, vb, vc, ea, eb, ec;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor)
    int          na = 0, nb = 0, nc = 0, nerr = 0, nerr_bc = 0;
    logic [31:0] la [8];
    logic [31:0] lb [8];
    logic [31:0] lc [8];
    logic [3:0]  la_idx = '0, lb_idx = '0;
    logic [31:0] q_pw0 [$];
    logic [3:0]  q_idx [$];

    always #5 clk = ~clk;

    ul_ant_power_acc #(.RBG_SIZE(2), .OUT_SHIFT(8)) u_a (
        .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_grp(grp),
        .i_ant0(ant), .i_ant1(ant), .i_ant2(ant), .i_ant3(ant),
        .i_rbg_idx(idx), .i_last_prb(last),
        .o_ant_power0(pa[0]), .o_ant_power1(pa[1]), .o_ant_power2(pa[2]), .o_ant_power3(pa[3]),
        .o_ant_power4(pa[4]), .o_ant_power5(pa[5]), .o_ant_power6(pa[6]), .o_ant_power7(pa[7]),
        .o_rbg_idx(ia), .o_pwr_vld(va), .o_err(ea)
    );

    ul_ant_power_acc #(.RBG_SIZE(16), .OUT_SHIFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_grp(grp),
        .i_ant0(ant), .i_ant1(ant), .i_ant2(ant), .i_ant3(ant),
        .i_rbg_idx(idx), .i_last_prb(last),
        .o_ant_power0(pb[0]), .o_ant_power1(pb[1]), .o_ant_power2(pb[2]), .o_ant_power3(pb[3]),
        .o_ant_power4(pb[4]), .o_ant_power5(pb[5]), .o_ant_power6(pb[6]), .o_ant_power7(pb[7]),
        .o_rbg_idx(ib), .o_pwr_vld(vb), .o_err(eb)
    );

    ul_ant_power_acc #(.RBG_SIZE(16), .OUT_SHIFT(8)) u_c (
        .clk(clk), .rst_n(rst_n), .i_vld(vld), .i_sop(sop), .i_eop(eop), .i_grp(grp),
        .i_ant0(ant), .i_ant1(ant), .i_ant2(ant), .i_ant3(ant),
        .i_rbg_idx(idx), .i_last_prb(last),
        .o_ant_power0(pc[0]), .o_ant_power1(pc[1]), .o_ant_power2(pc[2]), .o_ant_power3(pc[3]),
        .o_ant_power4(pc[4]), .o_ant_power5(pc[5]), .o_ant_power6(pc[6]), .o_ant_power7(pc[7]),
        .o_rbg_idx(ic), .o_pwr_vld(vc), .o_err(ec)
    );

    // Capture every dump and error pulse on the falling edge
    always @(negedge clk) begin
        if (va) begin
            na     <= na + 1;
            la     <= pa;
            la_idx <= ia;
            q_pw0.push_back(pa[0]);
            q_idx.push_back(ia);
        end
        if (vb) begin
            nb     <= nb + 1;
            lb     <= pb;
            lb_idx <= ib;
        end
        if (vc) begin
            nc <= nc + 1;
            lc <= pc;
        end
        if (ea) nerr <= nerr + 1;
        if (eb || ec) nerr_bc <= nerr_bc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic beat(input logic s, input logic e, input logic l, input logic g,
                        input logic [15:0] iv, input logic [15:0] qv, input logic [3:0] rx);
        vld = 1'b1; sop = s; eop = e; last = l; grp = g; ant = {iv, qv}; idx = rx;
        @(posedge clk); #1;
        vld = 1'b0; sop = 1'b0; eop = 1'b0; last = 1'b0;
    endtask

    task automatic prb(input int n, input logic l, input logic g, input logic alt,
                       input logic [15:0] iv, input logic [15:0] qv, input logic [3:0] rx);
        for (int k = 0; k < n; k++)
            beat(k == 0, k == n - 1, l && (k == n - 1), g ^ (alt & k[0]), iv, qv, rx);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nb0, nc0, ne0, nbe0;

        // Reset state
        idle(3);
        for (int a = 0; a < 8; a++) chk($sformatf("reset_pwr%0d", a), pa[a], 32'd0);
        chk("reset_idx", ia, 32'd0);
        chk("reset_vld", va, 32'd0);
        chk("reset_err", ea, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single PRB, grp 0, I=1000 Q=0: 12*1e6 >> 8 = 46875, latency 2 edges
        n0 = na;
        prb(12, 1'b1, 1'b0, 1'b0, 16'd1000, 16'd0, 4'd5);
        chk("t1_vld_n0", va, 32'd0);
        idle(1);
        chk("t1_vld_n1", va, 32'd0);
        idle(1);
        chk("t1_vld_n2", va, 32'd1);
        for (int a = 0; a < 8; a++)
            chk($sformatf("t1_pwr%0d", a), pa[a], (a < 4) ? 32'd46875 : 32'd0);
        chk("t1_idx", ia, 32'd5);
        idle(1);
        chk("t1_vld_n3", va, 32'd0);
        chk("t1_dump_count", na, n0 + 1);
        chk("t1_err_count", nerr, 32'd0);

        // 16 PRBs of full-scale -32768, grp 1: 192*2^31 saturates at shift 0, 3*2^29 at shift 8
        nb0 = nb; nc0 = nc; nbe0 = nerr_bc;
        for (int p = 0; p < 16; p++)
            prb(12, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h8000, 4'd7);
        idle(3);
        chk("t2_dump_count_s0", nb, nb0 + 1);
        chk("t2_dump_count_s8", nc, nc0 + 1);
        chk("t2_err_count", nerr_bc, nbe0);
        chk("t2_idx", lb_idx, 32'd7);
        for (int a = 0; a < 8; a++) begin
            chk($sformatf("t2_s0_pwr%0d", a), lb[a], (a >= 4) ? 32'hFFFF_FFFF : 32'd0);
            chk($sformatf("t2_s8_pwr%0d", a), lc[a], (a >= 4) ? 32'd1610612736 : 32'd0);
        end

        // Alternating group per beat, I=Q=100: 6*20000 >> 8 = 468 on every antenna
        n0 = na;
        prb(12, 1'b1, 1'b0, 1'b1, 16'd100, 16'd100, 4'd2);
        idle(3);
        chk("t3_dump_count", na, n0 + 1);
        chk("t3_idx", la_idx, 32'd2);
        for (int a = 0; a < 8; a++) chk($sformatf("t3_pwr%0d", a), la[a], 32'd468);

        // Back-to-back RBGs of 2 PRBs, I=200 Q=-300: 24*130000 >> 8 = 12187 each
        n0 = na;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 2; p++)
                prb(12, 1'b0, 1'b0, 1'b0, 16'd200, 16'hFED4, (r == 0) ? 4'd3 : 4'd9);
        idle(3);
        chk("t4_dump_count", na, n0 + 2);
        if (q_pw0.size() >= n0 + 2) begin
            chk("t4_first_pwr0", q_pw0[n0], 32'd12187);
            chk("t4_first_idx", q_idx[n0], 32'd3);
            chk("t4_second_pwr0", q_pw0[n0 + 1], 32'd12187);
            chk("t4_second_idx", q_idx[n0 + 1], 32'd9);
        end
        chk("t4_pwr4", la[4], 32'd0);

        // Framing errors: stray IDLE beat, 11-beat PRB, mid-PRB sop; 27 beats of 1e6 kept
        n0 = na; ne0 = nerr;
        beat(1'b0, 1'b0, 1'b0, 1'b0, 16'd1000, 16'd0, 4'd4);
        prb(11, 1'b0, 1'b0, 1'b0, 16'd1000, 16'd0, 4'd4);
        for (int k = 0; k < 16; k++)
            beat((k == 0) || (k == 4), k == 15, 1'b0, 1'b0, 16'd1000, 16'd0, 4'd4);
        idle(3);
        chk("t5_err_count", nerr, ne0 + 3);
        chk("t5_dump_count", na, n0 + 1);
        chk("t5_pwr0", la[0], 32'd105468);
        chk("t5_pwr4", la[4], 32'd0);
        chk("t5_idx", la_idx, 32'd4);

        // Reset in the middle of an RBG, then a clean RBG
        for (int k = 0; k < 6; k++)
            beat(k == 0, 1'b0, 1'b0, 1'b0, 16'd1000, 16'd0, 4'd1);
        rst_n = 1'b0;
        idle(1);
        chk("t6_reset_pwr0", pa[0], 32'd0);
        chk("t6_reset_idx", ia, 32'd0);
        rst_n = 1'b1;
        n0 = na;
        idle(1);
        prb(12, 1'b1, 1'b0, 1'b0, 16'd1000, 16'd0, 4'd6);
        idle(3);
        chk("t6_dump_count", na, n0 + 1);
        chk("t6_pwr0", la[0], 32'd46875);
        chk("t6_pwr3", la[3], 32'd46875);
        chk("t6_idx", la_idx, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
